// File: rtl/noc_packet_tx_pkg.sv
// noc_packet_tx_pkg: shared constants for the NoC packet transmitter.
//   NOC_DATA_WIDTH  default flit / payload word width
//   CSUM_EN         1 when the checksum flit is built in
//   tx_state_e      transmitter FSM states
//   hdr_*_lsb()     header field positions: {dest, src, len, zero pad}, MSB-first
// Build option: NOC_TX_CHECKSUM_EN adds the CSUM state and the checksum flit.
package noc_packet_tx_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 32;

`ifdef NOC_TX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY, ST_CSUM} tx_state_e;
`else
  localparam bit CSUM_EN = 1'b0;
  typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_BODY} tx_state_e;
`endif

  // Node ids (dest and src) share one width.
  function automatic int unsigned hdr_dest_lsb(int unsigned data_w, int unsigned dest_w);
    return data_w - dest_w;
  endfunction

  function automatic int unsigned hdr_src_lsb(int unsigned data_w, int unsigned dest_w);
    return data_w - 2 * dest_w;
  endfunction

  function automatic int unsigned hdr_len_lsb(int unsigned data_w, int unsigned dest_w,
                                              int unsigned len_w);
    return data_w - 2 * dest_w - len_w;
  endfunction

endpackage

// File: rtl/noc_packet_tx_if.sv
// noc_packet_tx_if: descriptor, payload and router flit ports of the transmitter.
//   pkt_*     descriptor handshake (dest, body length)
//   pld_*     payload word handshake
//   sender_*  flit handshake towards the router local input
//   busy, pkt_sent  status
// Modports: master = transmitter, slave = core/router side.
interface noc_packet_tx_if
  import noc_packet_tx_pkg::*;
#(
  parameter int unsigned DATA_W  = NOC_DATA_WIDTH,
  parameter int unsigned DEST_W  = 4,
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic              pkt_valid;
  logic              pkt_ready;
  logic [DEST_W-1:0] pkt_dest;
  logic [LEN_W-1:0]  pkt_len;
  logic              pld_valid;
  logic              pld_ready;
  logic [DATA_W-1:0] pld_data;
  logic              sender_valid;
  logic              sender_ready;
  logic [DATA_W-1:0] sender_flit;
  logic              sender_is_header;
  logic              sender_is_tail;
  logic              busy;
  logic              pkt_sent;

  modport master (
    input  pkt_valid, pkt_dest, pkt_len, pld_valid, pld_data, sender_ready,
    output pkt_ready, pld_ready, sender_valid, sender_flit, sender_is_header,
           sender_is_tail, busy, pkt_sent
  );

  modport slave (
    output pkt_valid, pkt_dest, pkt_len, pld_valid, pld_data, sender_ready,
    input  pkt_ready, pld_ready, sender_valid, sender_flit, sender_is_header,
           sender_is_tail, busy, pkt_sent
  );

endinterface

// File: rtl/noc_packet_tx_flit_out_reg.sv
// noc_flit_out_reg: registered valid/ready flit output stage.
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_*      flit + flags offered for loading this cycle
//   out_ready         downstream accepts
//   out_valid/flit/header/tail  registered outputs, held while stalled
//   load              register may take a new flit (empty or draining)
module noc_flit_out_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_flit,
  input  logic              push_header,
  input  logic              push_tail,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_flit,
  output logic              out_header,
  output logic              out_tail,
  output logic              load
);

  assign load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_flit   <= '0;
      out_header <= 1'b0;
      out_tail   <= 1'b0;
    end else if (load) begin
      out_valid  <= push;
      out_header <= push && push_header;
      out_tail   <= push && push_tail;
      if (push) out_flit <= push_flit;
    end
  end

endmodule

// File: rtl/noc_packet_tx.sv
// noc_packet_tx: NoC endpoint transmitter. Serialises a descriptor plus payload
// words into header, body flits and (optionally) a checksum flit.
//   noc_clk, noc_rst_n  clock, synchronous active-low reset
//   bus (master)        pkt_*, pld_*, sender_*, busy, pkt_sent
// Build option: NOC_TX_CHECKSUM_EN appends CSUM = XOR(header, body) as the tail.
module noc_packet_tx
  import noc_packet_tx_pkg::*;
#(
  parameter int unsigned DATA_W  = NOC_DATA_WIDTH,
  parameter int unsigned DEST_W  = 4,
  parameter int unsigned SRC_ID  = 0,
  parameter int unsigned MAX_LEN = 16
) (
  input logic            noc_clk,
  input logic            noc_rst_n,
  noc_packet_tx_if.master bus
);

  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1);
  localparam int unsigned DEST_LSB = hdr_dest_lsb(DATA_W, DEST_W);
  localparam int unsigned SRC_LSB  = hdr_src_lsb(DATA_W, DEST_W);
  localparam int unsigned LEN_LSB  = hdr_len_lsb(DATA_W, DEST_W, LEN_W);
  localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [DEST_W-1:0] SRC_V     = DEST_W'(SRC_ID);

  function automatic logic [DATA_W-1:0] pack_hdr(logic [DEST_W-1:0] d, logic [LEN_W-1:0] l);
    logic [DATA_W-1:0] h;
    h = '0;
    h[DEST_LSB +: DEST_W] = d;
    h[SRC_LSB  +: DEST_W] = SRC_V;
    h[LEN_LSB  +: LEN_W]  = l;
    return h;
  endfunction

  tx_state_e         state;
  logic [DEST_W-1:0] dest_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  in_len;
  logic              load;
  logic              push;
  logic [DATA_W-1:0] push_flit;
  logic              push_hdr;
  logic              push_tail;
  logic              pkt_ready_c;
  logic              pld_ready_c;
  logic              pkt_acc;
  logic              b2b;
  tx_state_e         done_state;

`ifdef NOC_TX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  // Header is pushed straight from IDLE so it appears the cycle after accept.
  // A descriptor taken while the previous tail is loading parks in HEAD.
  always_comb begin
    in_len      = (bus.pkt_len > MAX_LEN_V) ? MAX_LEN_V : bus.pkt_len;
    push        = 1'b0;
    push_flit   = '0;
    push_hdr    = 1'b0;
    push_tail   = 1'b0;
    pkt_ready_c = 1'b0;
    pld_ready_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        pkt_ready_c = load;
        if (load && bus.pkt_valid) begin
          push      = 1'b1;
          push_flit = pack_hdr(bus.pkt_dest, in_len);
          push_hdr  = 1'b1;
          push_tail = !CSUM_EN && (in_len == '0);
        end
      end
      ST_HEAD: begin
        if (load) begin
          push        = 1'b1;
          push_flit   = pack_hdr(dest_q, len_q);
          push_hdr    = 1'b1;
          push_tail   = !CSUM_EN && (len_q == '0);
          pkt_ready_c = push_tail;
        end
      end
      ST_BODY: begin
        pld_ready_c = load;
        if (load && bus.pld_valid) begin
          push        = 1'b1;
          push_flit   = bus.pld_data;
          push_tail   = !CSUM_EN && (rem_q == LEN_W'(1));
          pkt_ready_c = push_tail;
        end
      end
`ifdef NOC_TX_CHECKSUM_EN
      ST_CSUM: begin
        pkt_ready_c = load;
        if (load) begin
          push      = 1'b1;
          push_flit = csum_q;
          push_tail = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    pkt_acc = pkt_ready_c && bus.pkt_valid;
    b2b     = pkt_acc && (state != ST_IDLE);
`ifdef NOC_TX_CHECKSUM_EN
    done_state = ST_CSUM;
`else
    done_state = b2b ? ST_HEAD : ST_IDLE;
`endif
  end

  assign bus.pkt_ready = pkt_ready_c;
  assign bus.pld_ready = pld_ready_c;
  assign bus.busy      = (state != ST_IDLE) || bus.sender_valid;

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      state        <= ST_IDLE;
      dest_q       <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      bus.pkt_sent <= 1'b0;
    end else begin
      bus.pkt_sent <= bus.sender_valid && bus.sender_ready && bus.sender_is_tail;
      if (pkt_acc) begin
        dest_q <= bus.pkt_dest;
        len_q  <= in_len;
      end
      unique case (state)
        ST_IDLE: if (pkt_acc) begin
          rem_q <= in_len;
          if (in_len != '0) state <= ST_BODY;
          else if (CSUM_EN) state <= done_state;
        end
        ST_HEAD: if (push) begin
          rem_q <= len_q;
          state <= (len_q == '0) ? done_state : ST_BODY;
        end
        ST_BODY: if (push) begin
          rem_q <= rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state <= done_state;
        end
`ifdef NOC_TX_CHECKSUM_EN
        ST_CSUM: if (push) state <= pkt_acc ? ST_HEAD : ST_IDLE;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NOC_TX_CHECKSUM_EN
  // Header restarts the running XOR; every other pushed flit folds in.
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n)    csum_q <= '0;
    else if (push)     csum_q <= push_hdr ? push_flit : (csum_q ^ push_flit);
  end
`endif

  noc_flit_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk         (noc_clk),
    .rst_n       (noc_rst_n),
    .push        (push),
    .push_flit   (push_flit),
    .push_header (push_hdr),
    .push_tail   (push_tail),
    .out_ready   (bus.sender_ready),
    .out_valid   (bus.sender_valid),
    .out_flit    (bus.sender_flit),
    .out_header  (bus.sender_is_header),
    .out_tail    (bus.sender_is_tail),
    .load        (load)
  );

endmodule
